dp_ram_responder: RTL and testbench
===================================

Name: dp_ram_responder

Overview:
- Simple dual-port RAM that acts as the responder on the dual-port memory interface: one write port, one read port, both sampled on one clock.
- Sits behind the memory-bench driver as the DUT.
- After reset, runs a self-initialisation sweep that zeroes the array.
- Tracks which locations have been written since reset and flags reads of unwritten or out-of-range addresses.

Parameters:
- DEPTH, 16, number of words in the array (need not be a power of two).
- DWIDTH, 8, data word width in bits.
- AWIDTH, $clog2(DEPTH), address width in bits.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_enbl  input  1  write request, sampled at posedge.
- wr_addr  input  AWIDTH  write address.
- wr_data  input  DWIDTH  write data.
- rd_enbl  input  1  read request, sampled at posedge.
- rd_addr  input  AWIDTH  read address.
- rd_data  output  DWIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse, rd_data is the response to a read accepted on the previous edge.
- rd_err  output  1  one-cycle pulse coincident with rd_valid: unwritten or out-of-range read.
- init_busy  output  1  high while the init sweep runs; requests are ignored.
- req_dropped  output  1  sticky: a request arrived while init_busy was high; cleared only by rst.

Behaviour:
- Reset (already decided): one clock; reset is asynchronous and active-high.
- Port names are clk and rst.
- On rst assertion, immediately and regardless of clk: rd_data=0, rd_valid=0, rd_err=0, init_busy=1, req_dropped=0, written[] all 0, init counter=0, FSM=INIT.
- FSM has two states:
  - INIT: each posedge writes 0 to mem[init_cnt], then init_cnt++. When init_cnt==DEPTH-1 is written, go to RUN on that edge.
  - RUN: the normal operating state.
- init_busy is 1 in INIT and 0 in RUN. INIT lasts exactly DEPTH cycles after rst deassertion.
- In INIT:
  - wr_enbl and rd_enbl are ignored; the array is untouched except by the sweep.
  - rd_valid stays 0.
  - Any sampled wr_enbl or rd_enbl sets req_dropped.
- Write in RUN, wr_enbl=1 at edge N:
  - if wr_addr<DEPTH: mem[wr_addr]=wr_data and written[wr_addr]=1 at edge N;
  - if wr_addr>=DEPTH: silently ignored.
- Read in RUN, rd_enbl=1 at edge N:
  - at edge N+1: rd_valid=1 and rd_data=mem[rd_addr] as sampled at edge N;
  - rd_err=1 if rd_addr>=DEPTH (rd_data=0) or written[rd_addr]==0 (rd_data=0 from the init sweep).
- Latency is fixed at 1 cycle. Back-to-back reads every cycle are supported, with rd_valid held high continuously.
- No read at edge N: rd_valid=0 and rd_err=0 after edge N; rd_data holds its last value.
- Same-cycle write and read:
  - Same in-range address: write-first bypass. rd_data = new wr_data, rd_err=0, written bit set.
  - Different addresses: the two ports are fully independent.
- Reset mid-operation:
  - An outstanding read response is discarded (rd_valid forced 0).
  - Array contents are re-zeroed by a fresh INIT sweep; written[] is cleared.
- Wrap-around: none. Addresses are not modulo DEPTH; out-of-range addresses are handled as above.
- Memory array has no reset of its own; zeroing is by the INIT sweep only.

Test Plan:
- Reset, then count cycles -> init_busy=1 for exactly 16 posedges after rst falls, then 0. Read addr 5 -> rd_data=0x00, rd_valid=1, rd_err=1 one cycle later.
- In RUN, write 0xA5 to addr 3; next cycle read addr 3 -> one cycle later rd_data=0xA5, rd_valid=1, rd_err=0.
- Same edge: write 0x3C to addr 7 and read addr 7 -> rd_data=0x3C, rd_err=0 next cycle. A later read of 7 also returns 0x3C.
- Pulse wr_enbl during INIT (cycle 4 after reset), then read that address in RUN -> req_dropped=1 and stays 1; read returns 0x00 with rd_err=1.
- Fill addrs 0..15 with 0x10+i, then read 0..15 back-to-back -> rd_valid high 16 consecutive cycles, data 0x10..0x1F in order, rd_err=0 throughout.
- DEPTH=12 build: write addr 13 with 0xFF, read addr 13 -> rd_data=0x00 with rd_err=1. Then assert rst while a read is outstanding -> rd_valid=0 immediately, init_busy=1, previously written data reads back as 0x00.

Source files
------------

// File: rtl/dp_ram_if.sv
// Dual-port memory bus: one write port and one registered read port, plus
// responder status flags. The driver uses master, the RAM uses slave.
interface dp_ram_if #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = $clog2(DEPTH)
);
  logic              wr_enbl;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_enbl;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              init_busy;
  logic              req_dropped;

  modport master (
    output wr_enbl, wr_addr, wr_data, rd_enbl, rd_addr,
    input  rd_data, rd_valid, rd_err, init_busy, req_dropped
  );

  modport slave (
    input  wr_enbl, wr_addr, wr_data, rd_enbl, rd_addr,
    output rd_data, rd_valid, rd_err, init_busy, req_dropped
  );
endinterface

// File: rtl/dp_ram_responder.sv
// Simple dual-port RAM responder with a post-reset zeroing sweep, per-word
// written tracking and error flagging of unwritten / out-of-range reads.
module dp_ram_responder #(
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  dp_ram_if.slave  bus
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  // DEPTH need not be a power of two, so range checks use one extra bit.
  localparam logic [AWIDTH:0]   DEPTH_X  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] init_cnt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic              dropped;

  logic              busy_p0;
  logic              sweep_p0;
  logic              wr_in_p0;
  logic              rd_in_p0;
  logic              wr_go_p0;
  logic              rd_go_p0;
  logic              bypass_p0;

  logic [DWIDTH-1:0] data_p1;
  logic              vld_p1;
  logic              err_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Stage p0: request decode against current FSM state
  always_comb begin
    state_d   = state_q;
    busy_p0   = 1'b0;
    sweep_p0  = 1'b0;
    case (state_q)
      S_INIT: begin
        busy_p0  = 1'b1;
        sweep_p0 = 1'b1;
        if (init_cnt == LAST_IDX) state_d = S_RUN;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
    wr_in_p0  = ({1'b0, bus.wr_addr} < DEPTH_X);
    rd_in_p0  = ({1'b0, bus.rd_addr} < DEPTH_X);
    wr_go_p0  = !busy_p0 && bus.wr_enbl && wr_in_p0;
    rd_go_p0  = !busy_p0 && bus.rd_enbl;
    bypass_p0 = wr_go_p0 && rd_in_p0 && (bus.wr_addr == bus.rd_addr);
  end

  // The array itself is never reset; the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (sweep_p0)      mem[init_cnt]    <= '0;
    else if (wr_go_p0) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Stage p1: registered read response and control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= '0;
      written  <= '0;
      dropped  <= 1'b0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      if (sweep_p0) init_cnt <= init_cnt + 1'b1;
      if (busy_p0 && (bus.wr_enbl || bus.rd_enbl)) dropped <= 1'b1;
      if (wr_go_p0) written[bus.wr_addr] <= 1'b1;
      vld_p1 <= rd_go_p0;
      err_p1 <= 1'b0;
      if (rd_go_p0) begin
        if (!rd_in_p0) begin
          data_p1 <= '0;
          err_p1  <= 1'b1;
        end else if (bypass_p0) begin
          data_p1 <= bus.wr_data;
        end else begin
          // Unwritten words read back the zero left by the sweep.
          data_p1 <= mem[bus.rd_addr];
          err_p1  <= !written[bus.rd_addr];
        end
      end
    end
  end

  assign bus.rd_data     = data_p1;
  assign bus.rd_valid    = vld_p1;
  assign bus.rd_err      = err_p1;
  assign bus.init_busy   = busy_p0;
  assign bus.req_dropped = dropped;

endmodule

// File: tb/tb_dp_ram_responder.sv
// Scoreboard bench: drives identical traffic into a DEPTH=16 and a DEPTH=12
// responder and checks both against an array-level reference model.
module tb_dp_ram_responder;

  localparam int NDUT = 2;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_enbl;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_enbl;
  logic [3:0] rd_addr;

  always #5 clk = ~clk;

  dp_ram_if #(.DEPTH(16), .DWIDTH(8)) bus16 ();
  dp_ram_if #(.DEPTH(12), .DWIDTH(8)) bus12 ();

  assign bus16.wr_enbl = wr_enbl;
  assign bus16.wr_addr = wr_addr;
  assign bus16.wr_data = wr_data;
  assign bus16.rd_enbl = rd_enbl;
  assign bus16.rd_addr = rd_addr;
  assign bus12.wr_enbl = wr_enbl;
  assign bus12.wr_addr = wr_addr;
  assign bus12.wr_data = wr_data;
  assign bus12.rd_enbl = rd_enbl;
  assign bus12.rd_addr = rd_addr;

  dp_ram_responder #(.DEPTH(16), .DWIDTH(8)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  dp_ram_responder #(.DEPTH(12), .DWIDTH(8)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12));

  logic [7:0] o_data [NDUT];
  logic       o_vld  [NDUT];
  logic       o_err  [NDUT];
  logic       o_busy [NDUT];
  logic       o_drop [NDUT];

  assign o_data[0] = bus16.rd_data;   assign o_data[1] = bus12.rd_data;
  assign o_vld[0]  = bus16.rd_valid;  assign o_vld[1]  = bus12.rd_valid;
  assign o_err[0]  = bus16.rd_err;    assign o_err[1]  = bus12.rd_err;
  assign o_busy[0] = bus16.init_busy; assign o_busy[1] = bus12.init_busy;
  assign o_drop[0] = bus16.req_dropped; assign o_drop[1] = bus12.req_dropped;

  // Reference model state
  int         depth [NDUT] = '{16, 12};
  logic [7:0] m_mem [NDUT][16];
  bit         m_wr  [NDUT][16];
  int         m_init_left [NDUT];
  bit         m_drop [NDUT];
  logic [7:0] m_last [NDUT];
  exp_t       sbq [NDUT][$];

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s depth%0d actual=%0h expected=%0h t=%0t", name, depth[d], act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_init_left[d] = depth[d];
      m_drop[d] = 1'b0;
      m_last[d] = 8'h00;
      sbq[d].delete();
      for (int a = 0; a < 16; a++) begin
        m_mem[d][a] = 8'h00;
        m_wr[d][a]  = 1'b0;
      end
    end
  endfunction

  // Effect of one rising edge with the currently driven inputs.
  function automatic void model_step();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (m_init_left[d] > 0) begin
        if (wr_enbl || rd_enbl) m_drop[d] = 1'b1;
        m_init_left[d]--;
      end else begin
        if (rd_enbl) begin
          if (int'(rd_addr) >= depth[d])                     e = '{data: 8'h00, err: 1'b1};
          else if (wr_enbl && wr_addr == rd_addr)            e = '{data: wr_data, err: 1'b0};
          else e = '{data: m_mem[d][rd_addr], err: !m_wr[d][rd_addr]};
          sbq[d].push_back(e);
        end
        if (wr_enbl && int'(wr_addr) < depth[d]) begin
          m_mem[d][wr_addr] = wr_data;
          m_wr[d][wr_addr]  = 1'b1;
        end
      end
    end
  endfunction

  // Drive at a falling edge, account for the next rising edge, wait a cycle.
  task automatic cycle(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                       input bit re, input logic [3:0] ra);
    wr_enbl = we; wr_addr = wa; wr_data = wd;
    rd_enbl = re; rd_addr = ra;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic do_reset(input bit chk_now);
    rst = 1'b1;
    wr_enbl = 1'b0; rd_enbl = 1'b0;
    model_reset();
    #1;
    if (chk_now) begin
      for (int d = 0; d < NDUT; d++) begin
        check("rst_vld_async", d, 32'(o_vld[d]), 32'd0);
        check("rst_busy_async", d, 32'(o_busy[d]), 32'd1);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: sample just after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        check("init_busy", d, 32'(o_busy[d]), 32'(rst || m_init_left[d] > 0));
        check("req_dropped", d, 32'(o_drop[d]), 32'(m_drop[d]));
        if (o_vld[d]) begin
          if (sbq[d].size() == 0) begin
            check("unexpected_valid", d, 32'd1, 32'd0);
          end else begin
            e = sbq[d].pop_front();
            check("rd_data", d, 32'(o_data[d]), 32'(e.data));
            check("rd_err", d, 32'(o_err[d]), 32'(e.err));
            m_last[d] = e.data;
          end
        end else begin
          check("rd_err_idle", d, 32'(o_err[d]), 32'd0);
          check("rd_data_hold", d, 32'(o_data[d]), 32'(m_last[d]));
          if (sbq[d].size() != 0) begin
            check("missing_valid", d, 32'd0, 32'd1);
            void'(sbq[d].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    wr_enbl = 1'b0; wr_addr = '0; wr_data = '0;
    rd_enbl = 1'b0; rd_addr = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sweep length, then read of an unwritten word
    idle(16);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd5);
    // Write then read back
    cycle(1'b1, 4'd3, 8'hA5, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd3);
    // Same-edge write/read bypass, then a plain re-read
    cycle(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd7);
    idle(2);

    // Request during the sweep is dropped and leaves the array untouched
    do_reset(1'b0);
    idle(4);
    cycle(1'b1, 4'd9, 8'h55, 1'b0, 4'h0);
    idle(11);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd9);
    idle(1);

    // Fill every address, then stream reads back-to-back
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 8'(8'h10 + i), 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
    idle(1);

    // Address 13 is out of range for the 12-deep instance
    cycle(1'b1, 4'd13, 8'hFF, 1'b0, 4'h0);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd13);

    // Reset with a response on the bus, then re-read previously written data
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd3);
    do_reset(1'b1);
    idle(16);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd3);
    cycle(1'b0, 4'h0, 8'h00, 1'b1, 4'd10);
    idle(1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(1'b1);
      end else begin
        cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
